// File: rtl/rtc_lectura_if.sv
// ============================================================================
// rtc_lectura_if : read handshake between the RTC read sequencer and the bus controller.   rev 1.0
// ============================================================================
`default_nettype none

interface rtc_lectura_if;
  logic       rd_req;
  logic [7:0] address;
  logic       bus_done;
  logic [7:0] data_in;

  modport master (output rd_req, output address, input bus_done, input data_in);
  modport slave  (input rd_req, input address, output bus_done, output data_in);
endinterface

`default_nettype wire

// File: rtl/rtc_lectura.sv
// ============================================================================
// rtc_lectura : walks the RTC time/date/timer address table and latches each byte.   rev 1.0
// ============================================================================
`default_nettype none

module rtc_lectura #(
  parameter logic [11:0] TIMEOUT = 12'h0ff,
  parameter int          N_REG   = 9
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        leer,
  input  wire logic        escribe,
  rtc_lectura_if.master    bus,
  output logic             busy,
  output logic             frame_valid,
  output logic             timeout_err,
  output logic [7:0]       segundos,
  output logic [7:0]       minutos,
  output logic [7:0]       horas,
  output logic [7:0]       dia,
  output logic [7:0]       mes,
  output logic [7:0]       anio,
  output logic [7:0]       t_seg,
  output logic [7:0]       t_min,
  output logic [7:0]       t_hora
);

  localparam logic [3:0] LAST_IDX = 4'(N_REG - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_NEXT = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  idx;
  logic [11:0] cnt;
  logic [7:0]  regs [N_REG];

  logic start;
  logic latch;
  logic tmo;
  logic fin;

  function automatic logic [7:0] table_addr(input logic [3:0] i);
    case (i)
      4'd0:    table_addr = 8'h21;
      4'd1:    table_addr = 8'h22;
      4'd2:    table_addr = 8'h23;
      4'd3:    table_addr = 8'h24;
      4'd4:    table_addr = 8'h25;
      4'd5:    table_addr = 8'h26;
      4'd6:    table_addr = 8'h41;
      4'd7:    table_addr = 8'h42;
      4'd8:    table_addr = 8'h43;
      default: table_addr = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    latch    = 1'b0;
    tmo      = 1'b0;
    fin      = 1'b0;
    case (state)
      S_IDLE: begin
        if (leer && !escribe) begin
          state_nx = S_REQ;
          start    = 1'b1;
        end
      end
      S_REQ:  state_nx = S_WAIT;
      S_WAIT: begin
        // A completion landing on the timeout cycle still counts as success.
        if (bus.bus_done) begin
          latch    = 1'b1;
          state_nx = S_NEXT;
        end else if (cnt == TIMEOUT) begin
          tmo      = 1'b1;
          state_nx = S_NEXT;
        end
      end
      S_NEXT: begin
        if (idx == LAST_IDX) begin
          fin      = 1'b1;
          state_nx = S_IDLE;
        end else if (escribe) begin
          state_nx = S_IDLE;
        end else begin
          state_nx = S_REQ;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.rd_req  = (state == S_REQ);
  assign bus.address = (state == S_IDLE) ? 8'h00 : table_addr(idx);
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx         <= 4'd0;
      cnt         <= 12'd0;
      frame_valid <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < N_REG; i++) regs[i] <= 8'h00;
    end else begin
      frame_valid <= fin;
      if (start) begin
        idx         <= 4'd0;
        timeout_err <= 1'b0;
      end else if (state == S_NEXT && state_nx == S_REQ) begin
        idx <= idx + 4'd1;
      end
      if (state == S_REQ)       cnt <= 12'd0;
      else if (state == S_WAIT) cnt <= cnt + 12'd1;
      if (latch) regs[idx] <= bus.data_in;
      if (tmo)   timeout_err <= 1'b1;
    end
  end

  assign segundos = regs[0];
  assign minutos  = regs[1];
  assign horas    = regs[2];
  assign dia      = regs[3];
  assign mes      = regs[4];
  assign anio     = regs[5];
  assign t_seg    = regs[6];
  assign t_min    = regs[7];
  assign t_hora   = regs[8];

endmodule

`default_nettype wire

// File: tb/tb_rtc_lectura.sv
// ============================================================================
// tb_rtc_lectura : scoreboard bench for the RTC read sequencer.   rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rtc_lectura;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic leer     = 1'b0;
  logic esc_man  = 1'b0;
  logic esc_auto = 1'b0;
  wire  escribe  = esc_man | esc_auto;

  wire       busy, frame_valid, timeout_err;
  wire [7:0] segundos, minutos, horas, dia, mes, anio, t_seg, t_min, t_hora;

  rtc_lectura_if bus ();

  rtc_lectura dut (
    .clk(clk), .reset(reset), .leer(leer), .escribe(escribe), .bus(bus),
    .busy(busy), .frame_valid(frame_valid), .timeout_err(timeout_err),
    .segundos(segundos), .minutos(minutos), .horas(horas),
    .dia(dia), .mes(mes), .anio(anio),
    .t_seg(t_seg), .t_min(t_min), .t_hora(t_hora)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] tbl [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
  logic [7:0] exp_regs [9];
  logic [7:0] addr_q [$];

  logic [7:0] omit_addr = 8'h00;
  logic [7:0] slow_addr = 8'h00;
  logic [7:0] esc_addr  = 8'h00;
  logic [7:0] offs      = 8'h01;
  int         slow_dly  = 0;

  int fv_cnt  = 0;
  int rd_seen = 0;

  function automatic int get_delay(input logic [7:0] a);
    if (a == omit_addr) return -1;
    if (a == slow_addr) return slow_dly;
    return 2;
  endfunction

  function automatic int idx_of(input logic [7:0] a);
    for (int i = 0; i < 9; i++) if (tbl[i] == a) return i;
    return 0;
  endfunction

  // Bus controller model: pops the expected address on each request and answers after a delay.
  logic [7:0] cur_addr = 8'h00;
  int         wcnt = 0, dly = 0;
  bit         pend = 0;
  always @(negedge clk) begin
    logic [31:0] exp_a;
    bus.bus_done = 1'b0;
    if (frame_valid) fv_cnt++;
    if (bus.rd_req) begin
      rd_seen++;
      if (addr_q.size() > 0) exp_a = {24'h0, addr_q.pop_front()};
      else                   exp_a = 32'hDEAD;
      check("addr_order", {24'h0, bus.address}, exp_a);
      cur_addr = bus.address;
      wcnt     = 0;
      pend     = 1;
      dly      = get_delay(cur_addr);
      if (cur_addr == esc_addr) esc_auto = 1'b1;
    end else if (pend) begin
      if (dly >= 0 && wcnt == dly) begin
        bus.bus_done = 1'b1;
        bus.data_in  = cur_addr + offs;
        exp_regs[idx_of(cur_addr)] = cur_addr + offs;
        pend = 0;
      end
      wcnt++;
    end
  end

  task automatic push_addrs(input int n);
    for (int i = 0; i < n; i++) addr_q.push_back(tbl[i % 9]);
  endtask

  task automatic start_frame();
    @(negedge clk) leer = 1'b1;
    @(negedge clk) leer = 1'b0;
    check("first_req", {31'h0, bus.rd_req}, 32'h1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("frame_wait", {31'h0, busy}, 32'h0);
  endtask

  task automatic compare_regs(input string tag);
    logic [7:0] d [9];
    d = '{segundos, minutos, horas, dia, mes, anio, t_seg, t_min, t_hora};
    for (int i = 0; i < 9; i++)
      check($sformatf("%s_reg%0d", tag, i), {24'h0, d[i]}, {24'h0, exp_regs[i]});
  endtask

  task automatic wait_fv(input string tag, input int budget);
    int n = 0;
    while (!frame_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'h0, frame_valid}, 32'h1);
  endtask

  initial begin
    int fv0, rd0;
    bus.bus_done = 1'b0;
    bus.data_in  = 8'h00;
    for (int i = 0; i < 9; i++) exp_regs[i] = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_rd_req", {31'h0, bus.rd_req}, 32'h0);
    check("rst_address", {24'h0, bus.address}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_fv", {31'h0, frame_valid}, 32'h0);
    check("rst_terr", {31'h0, timeout_err}, 32'h0);
    compare_regs("rst");
    reset = 1'b0;

    // Normal frame, data = address + 1
    offs = 8'h01;
    push_addrs(9);
    fv0 = fv_cnt;
    start_frame();
    wait_idle(400);
    @(negedge clk);
    check("t1_fv_count", fv_cnt - fv0, 1);
    check("t1_segundos", {24'h0, segundos}, 32'h22);
    check("t1_anio", {24'h0, anio}, 32'h27);
    check("t1_t_hora", {24'h0, t_hora}, 32'h44);
    check("t1_busy", {31'h0, busy}, 32'h0);
    check("t1_q_empty", addr_q.size(), 0);
    compare_regs("t1");

    // Start blocked while the write sequencer owns the bus
    esc_man = 1'b1;
    leer    = 1'b1;
    rd0     = rd_seen;
    repeat (10) @(negedge clk);
    check("t2_no_req", rd_seen - rd0, 0);
    check("t2_address", {24'h0, bus.address}, 32'h0);
    check("t2_busy", {31'h0, busy}, 32'h0);
    leer    = 1'b0;
    esc_man = 1'b0;

    // Missing completion for 0x23 -> timeout, horas keeps its value
    offs      = 8'h11;
    omit_addr = 8'h23;
    push_addrs(9);
    fv0 = fv_cnt;
    start_frame();
    wait_idle(1000);
    @(negedge clk);
    omit_addr = 8'h00;
    check("t3_fv_count", fv_cnt - fv0, 1);
    check("t3_terr", {31'h0, timeout_err}, 32'h1);
    check("t3_horas", {24'h0, horas}, 32'h24);
    compare_regs("t3");

    // escribe raised during the read of 0x24 -> abort after that read
    offs     = 8'h30;
    esc_addr = 8'h24;
    push_addrs(4);
    fv0 = fv_cnt;
    start_frame();
    check("t4_terr_clr", {31'h0, timeout_err}, 32'h0);
    wait_idle(400);
    repeat (2) @(negedge clk);
    esc_auto = 1'b0;
    esc_addr = 8'h00;
    check("t4_no_fv", fv_cnt - fv0, 0);
    check("t4_dia", {24'h0, dia}, 32'h54);
    check("t4_mes", {24'h0, mes}, 32'h36);
    check("t4_q_empty", addr_q.size(), 0);
    compare_regs("t4");

    // Completion exactly on the timeout cycle wins
    offs      = 8'h40;
    slow_addr = 8'h21;
    slow_dly  = 255;
    push_addrs(9);
    start_frame();
    wait_idle(1000);
    @(negedge clk);
    slow_addr = 8'h00;
    check("t5_terr", {31'h0, timeout_err}, 32'h0);
    check("t5_segundos", {24'h0, segundos}, 32'h61);
    compare_regs("t5");

    // Asynchronous reset while waiting on 0x41
    offs      = 8'h05;
    omit_addr = 8'h41;
    push_addrs(9);
    start_frame();
    for (int n = 0; n < 200 && !(bus.rd_req && bus.address == 8'h41); n++) @(negedge clk);
    check("t6_reached_41", {24'h0, bus.address}, 32'h41);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6_rd_req", {31'h0, bus.rd_req}, 32'h0);
    check("t6_address", {24'h0, bus.address}, 32'h0);
    check("t6_busy", {31'h0, busy}, 32'h0);
    check("t6_segundos", {24'h0, segundos}, 32'h0);
    check("t6_t_hora", {24'h0, t_hora}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    addr_q.delete();
    omit_addr = 8'h00;
    for (int i = 0; i < 9; i++) exp_regs[i] = 8'h00;

    // leer held high -> back-to-back frames separated by one idle cycle
    push_addrs(18);
    leer = 1'b1;
    wait_fv("t7_fv1", 200);
    check("t7_gap_idle", {31'h0, busy}, 32'h0);
    @(negedge clk);
    check("t7_restart", {31'h0, bus.rd_req}, 32'h1);
    @(negedge clk);
    wait_fv("t7_fv2", 200);
    leer = 1'b0;
    repeat (2) @(negedge clk);
    check("t7_stop", {31'h0, busy}, 32'h0);
    check("t7_q_empty", addr_q.size(), 0);
    compare_regs("t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/rtc_lectura.md
Name: rtc_lectura

Overview:
- Read sequencer for the RTC parallel bus. It is the counterpart of the initialization/write sequencer, which clears the RTC time and timer registers.
- On request, it walks a fixed table of RTC register addresses and issues one read per address to the bus controller through a req/done handshake.
- Each returned byte is latched into a dedicated BCD output register.
- The display and compare logic read the time/date/timer values from this block.

Parameters:
- TIMEOUT, 12'h0ff, max clk cycles to wait for bus_done before abandoning the current address.
- N_REG, 9, number of table entries (fixed table; must be 9).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- leer  input  1  start request; sampled only in IDLE
- escribe  input  1  write sequencer owns the bus; blocks start
- bus_done  input  1  one-cycle pulse from the bus controller: read finished, data_in valid
- data_in  input  8  byte read from the RTC
- rd_req  output  1  read request to the bus controller
- address  output  8  RTC register address for the current read
- busy  output  1  high from leaving IDLE until return to IDLE
- frame_valid  output  1  one-cycle pulse when a full table pass completes
- timeout_err  output  1  sticky; set on any timeout, cleared at next frame start
- segundos, minutos, horas  output  8 each  latched from 0x21, 0x22, 0x23
- dia, mes, anio  output  8 each  latched from 0x24, 0x25, 0x26
- t_seg, t_min, t_hora  output  8 each  latched from 0x41, 0x42, 0x43

Behaviour:
- Reset (async, immediate):
  - State IDLE; index 0; timeout counter 0.
  - rd_req=0, address=8'h00, busy=0, frame_valid=0, timeout_err=0.
  - All nine data registers = 8'h00.
- Address table, index 0..8: 0x21, 0x22, 0x23, 0x24, 0x25, 0x26, 0x41, 0x42, 0x43. address is never high-Z; it is 8'h00 in IDLE.
- State machine (registered, on posedge clk):
  - IDLE: if leer && !escribe, go to REQ. Clear index and timeout_err; busy=1 from the next cycle.
  - REQ:
    - address = table[index]; rd_req=1 for exactly one cycle; counter cleared; go to WAIT.
    - address stays stable from REQ through the end of WAIT.
  - WAIT:
    - rd_req=0; counter increments each cycle.
    - If bus_done=1: latch data_in into the register for the current index in that same edge, then go to NEXT.
    - Else if counter==TIMEOUT: set timeout_err=1, keep the old register value, go to NEXT.
    - bus_done and the timeout in the same cycle: bus_done wins (data latched, no error).
  - NEXT:
    - If index==N_REG-1: pulse frame_valid for one cycle and go to IDLE.
    - Else: index+1 and go to REQ.
  - IDLE after a frame:
    - busy=0.
    - If leer is still held and escribe=0, a new frame starts the following cycle.
    - Continuous refresh is therefore achieved by holding leer high.
- escribe asserted mid-frame:
  - The current read completes (or times out).
  - The FSM then returns to IDLE without finishing the table and without a frame_valid pulse.
  - Registers already updated keep their new values.
- bus_done outside WAIT is ignored.
- Latency:
  - Start to first rd_req: 1 cycle after leer is sampled.
  - Each entry takes 1 (REQ) + k (WAIT, up to bus_done) + 1 (NEXT) cycles.
  - Best-case frame with bus_done on the first WAIT cycle: 9×3 = 27 cycles from REQ0 to the frame_valid pulse.
- Data is stored raw (BCD, as read). No arithmetic or range checks.
- Reset mid-frame: immediate return to reset values; no partial pulse.

Test Plan:
- Reset release, then leer=1 pulse with escribe=0; the bus model answers bus_done 3 cycles after each rd_req with data = address+1 -> addresses 21..26, 41..43 in order; segundos=8'h22, anio=8'h27, t_hora=8'h44; single frame_valid pulse; busy falls afterwards.
- leer=1 while escribe=1 -> stays IDLE; rd_req never asserted; address=8'h00; busy=0.
- Bus model omits bus_done for address 0x23 only -> after TIMEOUT cycles timeout_err=1; horas keeps its previous value; frame still completes with frame_valid; next frame start clears timeout_err.
- escribe raised during the read of 0x24 -> the 0x24 read completes; FSM goes to IDLE; no frame_valid; dia is updated, mes and anio are unchanged.
- bus_done asserted on exactly the timeout cycle -> data latched; timeout_err stays 0.
- reset asserted while in WAIT for 0x41 -> all outputs read 0 immediately, asynchronously before the next clk edge. Hold leer high afterwards -> back-to-back frames with one IDLE cycle between them.
